// File: rtl/des_key_schedule.sv
`default_nettype none
// ============================================================================
// des_key_schedule : iterative DES subkey generator; PC1 on key accept, then
//   PC2 subkeys K1..K16 (encrypt) or K16..K1 (decrypt), one per handshake.
// Option macro     : DES_KS_PARITY_CHECK_EN (odd-parity key reject pulse).
// Revision         : 1.0  initial release
// ============================================================================
module des_key_schedule #(
  parameter int OUT_REG = 1,
  parameter int IDX_W   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [0:63]      i_key,
  input  logic             i_key_decrypt,
  input  logic             i_key_valid,
  output logic             o_key_ready,
  output logic [0:47]      o_subkey,
  output logic [IDX_W-1:0] o_subkey_idx,
  output logic             o_subkey_last,
  output logic             o_subkey_valid,
  input  logic             i_subkey_ready,
  output logic             o_parity_err
);

  localparam int c_pc1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int c_pc2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  logic [0:55]      r_cd;
  logic [4:0]       r_round;
  logic             r_decrypt;
  logic             r_key_ready;
  logic             r_parity_err;

  logic [0:55]      w_pc1;
  logic [0:47]      w_pc2;
  logic [0:55]      w_cd_next;
  logic [0:55]      w_cd_load;
  logic [4:0]       w_shift_sel;
  logic             w_two;
  logic [4:0]       w_idx5;
  logic [IDX_W-1:0] w_idx;
  logic             w_gen_valid;
  logic             w_slot_free;
  logic             w_out_fire;
  logic             w_adv;
  logic             w_parity_bad;

  function automatic logic [0:27] rotl28(input logic [0:27] v, input logic two);
    rotl28 = two ? {v[2:27], v[0:1]} : {v[1:27], v[0]};
  endfunction

  function automatic logic [0:27] rotr28(input logic [0:27] v, input logic two);
    rotr28 = two ? {v[26:27], v[0:25]} : {v[27], v[0:26]};
  endfunction

  // Rounds 1, 2, 9 and 16 shift by one; every other round shifts by two.
  function automatic logic shift_is_two(input logic [4:0] n);
    shift_is_two = !((n == 5'd1) || (n == 5'd2) || (n == 5'd9) || (n == 5'd16));
  endfunction

  for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
    assign w_pc1[gi] = i_key[c_pc1[gi]-1];
  end

  for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
    assign w_pc2[gi] = r_cd[c_pc2[gi]-1];
  end

  assign w_shift_sel = r_decrypt ? (5'd17 - r_round) : (r_round + 5'd1);
  assign w_two       = shift_is_two(w_shift_sel);
  assign w_cd_next   = r_decrypt ? {rotr28(r_cd[0:27], w_two), rotr28(r_cd[28:55], w_two)}
                                 : {rotl28(r_cd[0:27], w_two), rotl28(r_cd[28:55], w_two)};
  // Decrypt starts from C0D0, which equals C16D16 after the full 28-bit rotation.
  assign w_cd_load   = i_key_decrypt ? w_pc1
                                     : {rotl28(w_pc1[0:27], 1'b0), rotl28(w_pc1[28:55], 1'b0)};

  assign w_idx5      = r_decrypt ? (5'd17 - r_round) : r_round;
  assign w_idx       = IDX_W'(w_idx5);
  assign w_gen_valid = (r_state == S_RUN);
  assign w_adv       = w_gen_valid && w_slot_free;
  assign o_key_ready = r_key_ready;
  assign o_parity_err = r_parity_err;

`ifdef DES_KS_PARITY_CHECK_EN
  logic [7:0] w_byte_odd;
  for (genvar gb = 0; gb < 8; gb++) begin : g_par
    assign w_byte_odd[gb] = ^i_key[gb*8 +: 8];
  end
  assign w_parity_bad = ~&w_byte_odd;
`else
  logic w_unused_par;
  assign w_unused_par = ^{i_key[7], i_key[15], i_key[23], i_key[31],
                          i_key[39], i_key[47], i_key[55], i_key[63]};
  assign w_parity_bad = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_cd         <= '0;
      r_round      <= '0;
      r_decrypt    <= 1'b0;
      r_key_ready  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_key_valid && r_key_ready) begin
            if (w_parity_bad) begin
              r_parity_err <= 1'b1;
            end else begin
              r_decrypt   <= i_key_decrypt;
              r_round     <= 5'd1;
              r_cd        <= w_cd_load;
              r_state     <= S_RUN;
              r_key_ready <= 1'b0;
            end
          end else begin
            r_key_ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_adv) begin
            if (r_round == 5'd16) begin
              if (OUT_REG != 0) begin
                r_state <= S_DRAIN;
              end else begin
                r_state     <= S_IDLE;
                r_key_ready <= 1'b1;
              end
            end else begin
              r_round <= r_round + 5'd1;
              r_cd    <= w_cd_next;
            end
          end
        end
        S_DRAIN: begin
          if (w_out_fire) begin
            r_state     <= S_IDLE;
            r_key_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_key_ready <= 1'b0;
        end
      endcase
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic             r_out_valid;
    logic [0:47]      r_out_subkey;
    logic [IDX_W-1:0] r_out_idx;
    logic             r_out_last;

    // Single-entry skid: refill in the same cycle the held entry is taken.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_out_valid  <= 1'b0;
        r_out_subkey <= '0;
        r_out_idx    <= '0;
        r_out_last   <= 1'b0;
      end else if (w_adv) begin
        r_out_valid  <= 1'b1;
        r_out_subkey <= w_pc2;
        r_out_idx    <= w_idx;
        r_out_last   <= (r_round == 5'd16);
      end else if (i_subkey_ready) begin
        r_out_valid  <= 1'b0;
      end
    end

    assign w_slot_free    = !r_out_valid || i_subkey_ready;
    assign w_out_fire     = r_out_valid && i_subkey_ready;
    assign o_subkey_valid = r_out_valid;
    assign o_subkey       = r_out_subkey;
    assign o_subkey_idx   = r_out_idx;
    assign o_subkey_last  = r_out_last;
  end else begin : g_out_comb
    assign w_slot_free    = i_subkey_ready;
    assign w_out_fire     = 1'b0;
    assign o_subkey_valid = w_gen_valid;
    assign o_subkey       = w_pc2;
    assign o_subkey_idx   = w_idx;
    assign o_subkey_last  = w_gen_valid && (r_round == 5'd16);
  end

endmodule
`default_nettype wire

// File: tb/tb_des_key_schedule.sv
`default_nettype none
// tb_des_key_schedule: directed-vector bench for des_key_schedule (OUT_REG=1, IDX_W=5)
// using the classic 0x133457799BBCDFF1 subkey table.
module tb_des_key_schedule;
  localparam int P_IDX_W = 5;
  localparam logic [63:0] c_key = 64'h133457799BBCDFF1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [0:63]        key;
  logic               key_decrypt;
  logic               key_valid;
  logic               key_ready;
  logic [0:47]        subkey;
  logic [P_IDX_W-1:0] subkey_idx;
  logic               subkey_last;
  logic               subkey_valid;
  logic               subkey_ready;
  logic               parity_err;

  int n_total = 0;
  int n_bad   = 0;
  int waits;

  logic [47:0] ks_tab [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  always #5 clk = ~clk;

  des_key_schedule #(.OUT_REG(1), .IDX_W(P_IDX_W)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_key          (key),
    .i_key_decrypt  (key_decrypt),
    .i_key_valid    (key_valid),
    .o_key_ready    (key_ready),
    .o_subkey       (subkey),
    .o_subkey_idx   (subkey_idx),
    .o_subkey_last  (subkey_last),
    .o_subkey_valid (subkey_valid),
    .i_subkey_ready (subkey_ready),
    .o_parity_err   (parity_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 64'(subkey_valid), 0);
    check_eq({tag, "_subkey"}, 64'(subkey), 0);
    check_eq({tag, "_idx"}, 64'(subkey_idx), 0);
    check_eq({tag, "_last"}, 64'(subkey_last), 0);
    check_eq({tag, "_perr"}, 64'(parity_err), 0);
    check_eq({tag, "_kready"}, 64'(key_ready), 0);
  endtask

  // Called at a negedge; returns at a negedge with key_ready expected high.
  task automatic run_stream(input logic [63:0] k, input logic dec, input bit zero_key,
                            input bit stall, input bit poke, input bit hold,
                            input int abort_at, output int n_wait);
    int lat, hs, exp_idx;
    bit pend, seen_first, perr_seen;
    logic [47:0] h_sk, exp_sk;
    logic [P_IDX_W-1:0] h_idx;
    logic h_last;
    key = k; key_decrypt = dec; key_valid = 1'b1; n_wait = 0;
    while (!key_ready && n_wait < 50) begin
      @(negedge clk);
      n_wait++;
    end
    if (!key_ready) begin
      check_eq("accept_timeout", 0, 1);
      key_valid = 1'b0;
      return;
    end
    subkey_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    lat = 0; hs = 0; pend = 0; seen_first = 0; perr_seen = 0;
    while (hs < 16 && lat < 400) begin
      @(negedge clk);
      lat++;
      if (lat == 1) key_valid = 1'b0;
      if (parity_err) perr_seen = 1;
      if (poke) begin
        key_valid = 1'($urandom_range(0, 1));
        key = ~k; key_decrypt = ~dec;
      end
      if (pend) begin
        check_eq("hold_valid", 64'(subkey_valid), 1);
        check_eq("hold_data", {subkey, subkey_idx, subkey_last}, {h_sk, h_idx, h_last});
      end
      if (subkey_valid && !seen_first) begin
        seen_first = 1;
        check_eq("latency", lat, 2);
      end
      if (subkey_valid && abort_at == hs + 1) begin
        rst_n = 1'b0;
        key_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        return;
      end
      subkey_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (subkey_valid) begin
        if (subkey_ready) begin
          exp_idx = dec ? 16 - hs : hs + 1;
          exp_sk  = zero_key ? 48'h0 : ks_tab[exp_idx-1];
          check_eq("subkey", 64'(subkey), 64'(exp_sk));
          check_eq("idx_last", {subkey_idx, subkey_last}, {P_IDX_W'(exp_idx), hs == 15});
          hs++;
          pend = 0;
          if (hs == 16) begin
            key_valid = hold;
            key = k; key_decrypt = dec;
          end
        end else begin
          pend = 1;
          h_sk = subkey; h_idx = subkey_idx; h_last = subkey_last;
        end
      end
    end
    if (hs < 16) begin
      check_eq("stream_timeout", hs, 16);
      return;
    end
    @(negedge clk);
    check_eq("ready_after_last", 64'(key_ready), 1);
    check_eq("no_parity_err", 64'(perr_seen), 0);
  endtask

  initial begin
    rst_n = 1'b0; key = '0; key_decrypt = 1'b0; key_valid = 1'b0; subkey_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_reset", 64'(key_ready), 1);

    run_stream(c_key, 1'b0, 0, 0, 0, 0, 0, waits);
    run_stream(c_key, 1'b1, 0, 0, 0, 0, 0, waits);
    run_stream(c_key, 1'b0, 0, 1, 1, 0, 0, waits);

    // Back-to-back: second key held valid across the end of the first stream.
    run_stream(c_key, 1'b0, 0, 0, 0, 1, 0, waits);
    run_stream(c_key, 1'b1, 0, 0, 0, 0, 0, waits);
    check_eq("b2b_waits", waits, 0);

    run_stream(c_key, 1'b0, 0, 0, 0, 0, 7, waits);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_midreset", 64'(key_ready), 1);
    run_stream(c_key, 1'b0, 0, 0, 0, 0, 0, waits);

`ifdef DES_KS_PARITY_CHECK_EN
    key = '0; key_decrypt = 1'b0; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check_eq("perr_pulse", 64'(parity_err), 1);
    check_eq("perr_kready", 64'(key_ready), 1);
    check_eq("perr_novalid", 64'(subkey_valid), 0);
    @(negedge clk);
    check_eq("perr_clear", 64'(parity_err), 0);
    check_eq("perr_novalid2", 64'(subkey_valid), 0);
    run_stream(c_key, 1'b0, 0, 0, 0, 0, 0, waits);
`else
    run_stream(64'h0, 1'b0, 1, 0, 0, 0, 0, waits);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
